// File: rtl/modex_result_sequencer.sv
// modex_result_sequencer
// Drives one decryption pass. For each encrypted word it presents the byte
// address, pulses the exponentiator start and waits for the rising edge of its
// finish flag, bounded by a timeout. It then clamps the 16-bit result to an
// 8-bit pixel and writes it, counting saturated and abandoned words per frame.
module modex_result_sequencer #(
  parameter int ARQ       = 16,
  parameter int ADDR      = 18,
  parameter int NUM_WORDS = 16384,
  parameter int TIMEOUT   = 4096
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            finish_i,
  input  logic [ARQ-1:0]  decrypted_i,
  output logic            modex_start_o,
  output logic [ADDR-1:0] address_o,
  output logic            wr_en_o,
  output logic [ADDR-1:0] wr_addr_o,
  output logic [7:0]      wr_data_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [15:0]     sat_count_o,
  output logic [15:0]     tmo_count_o
);

  // The word index needs one bit less than the byte address (two bytes per word).
  localparam int IW = ADDR - 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    WRITE,
    DONE
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   wordIdx_q;
  logic [CW-1:0]   waitCnt_q;
  logic            finish_q;
  logic            modexStart_q;
  logic [ADDR-1:0] address_q;
  logic            wrEn_q;
  logic [ADDR-1:0] wrAddr_q;
  logic [7:0]      wrData_q;
  logic            busy_q;
  logic            done_q;
  logic [15:0]     satCount_q;
  logic [15:0]     tmoCount_q;

  logic            finishRise;
  logic            timeoutHit;
  logic            overRange;
  logic [ARQ-1:0]  capture_d;
  logic [7:0]      pixel_d;
  logic [IW-1:0]   wordIdx_d;

  // Edge/timeout detection and the clamped pixel a WAIT exit would capture.
  always_comb begin
    finishRise = finish_i & ~finish_q;
    timeoutHit = (waitCnt_q == LAST_CNT);
    capture_d  = finishRise ? decrypted_i : '0;
    overRange  = |capture_d[ARQ-1:8];
    pixel_d    = overRange ? 8'hFF : capture_d[7:0];
    wordIdx_d  = wordIdx_q + 1'b1;
  end

  // Frame sequencer with all outputs registered; a finish edge beats a same-cycle timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wordIdx_q    <= '0;
      waitCnt_q    <= '0;
      finish_q     <= 1'b0;
      modexStart_q <= 1'b0;
      address_q    <= '0;
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      satCount_q   <= '0;
      tmoCount_q   <= '0;
    end else begin
      finish_q     <= finish_i;
      modexStart_q <= 1'b0;
      wrEn_q       <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q      <= LOAD;
            wordIdx_q    <= '0;
            address_q    <= '0;
            modexStart_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            satCount_q   <= '0;
            tmoCount_q   <= '0;
          end
        end
        LOAD: begin
          state_q   <= WAIT;
          waitCnt_q <= '0;
        end
        WAIT: begin
          if (finishRise || timeoutHit) begin
            state_q  <= WRITE;
            wrEn_q   <= 1'b1;
            wrAddr_q <= {1'b0, wordIdx_q};
            wrData_q <= pixel_d;
            if (overRange && (satCount_q != 16'hFFFF)) begin
              satCount_q <= satCount_q + 16'd1;
            end
            if (!finishRise && (tmoCount_q != 16'hFFFF)) begin
              tmoCount_q <= tmoCount_q + 16'd1;
            end
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        WRITE: begin
          if (wordIdx_q == LAST_IDX) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q      <= LOAD;
            wordIdx_q    <= wordIdx_d;
            address_q    <= {wordIdx_d, 1'b0};
            modexStart_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign modex_start_o = modexStart_q;
  assign address_o     = address_q;
  assign wr_en_o       = wrEn_q;
  assign wr_addr_o     = wrAddr_q;
  assign wr_data_o     = wrData_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign sat_count_o   = satCount_q;
  assign tmo_count_o   = tmoCount_q;

endmodule
